// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - pipeline write-back stage: load byte/half extraction, fault flagging, retire counter.
// Inputs are decoded combinationally into a next state; every output comes straight from a register.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_exc,
  output logic [31:0]       wb_retire_cnt
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              exc_q, exc_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;
  logic              misaligned;
  logic              wd_nz;
  logic              fault;
  logic              cap_we;
  logic [DATA_W-1:0] cap_data;

  // Big-endian lanes: offset 0 is the most significant byte of the word.
  always_comb begin
    byte_sel = 8'h00;
    case (mem_addr_lo)
      2'd0: byte_sel = mem_rdata[31:24];
      2'd1: byte_sel = mem_rdata[23:16];
      2'd2: byte_sel = mem_rdata[15:8];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  always_comb begin
    load_data  = '0;
    misaligned = 1'b1;
    case (mem_load_op)
      OP_LB: begin
        load_data  = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        misaligned = 1'b0;
      end
      OP_LBU: begin
        load_data  = {{(DATA_W-8){1'b0}}, byte_sel};
        misaligned = 1'b0;
      end
      OP_LH: begin
        load_data  = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misaligned = mem_addr_lo[0];
      end
      OP_LHU: begin
        load_data  = {{(DATA_W-16){1'b0}}, half_sel};
        misaligned = mem_addr_lo[0];
      end
      OP_LW: begin
        load_data  = mem_rdata;
        misaligned = (mem_addr_lo != 2'd0);
      end
      default: begin
        load_data  = '0;
        misaligned = 1'b1;
      end
    endcase
  end

  // Writes to register 0 are dropped outright, so they can neither fault nor retire.
  always_comb begin
    wd_nz    = |mem_wd;
    fault    = mem_is_load & mem_wreg & wd_nz & misaligned;
    cap_we   = mem_wreg & wd_nz & ~fault;
    cap_data = fault ? '0 : (mem_is_load ? load_data : mem_wdata);
  end

  always_comb begin
    we_d         = we_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    exc_d        = exc_q;
    retire_cnt_d = retire_cnt_q;
    if (flush || (stall_mem && !stall_wb)) begin
      we_d    = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      exc_d   = 1'b0;
    end else if (!stall_wb) begin
      we_d         = cap_we;
      waddr_d      = mem_wd;
      wdata_d      = cap_data;
      exc_d        = fault;
      retire_cnt_d = retire_cnt_q + {31'd0, cap_we};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      exc_q        <= 1'b0;
      retire_cnt_q <= 32'd0;
    end else begin
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      exc_q        <= exc_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_we         = we_q;
  assign wb_waddr      = waddr_q;
  assign wb_wdata      = wdata_q;
  assign wb_exc        = exc_q;
  assign wb_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed vector table plus stall/flush/wrap/reset sequences for wb_stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic        mem_is_load = 1'b0;
  logic [2:0]  mem_load_op = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic [31:0] mem_rdata = '0;
  logic        stall_mem = 1'b0;
  logic        stall_wb = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_exc;
  logic [31:0] wb_retire_cnt;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_cnt = '0;

  localparam logic [31:0] W = 32'h80FF7F01;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        ld;
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_exc;
    logic        chk_d;
  } vec_t;

  vec_t vecs[$];

  wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_is_load(mem_is_load), .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo),
    .mem_rdata(mem_rdata), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_exc(wb_exc),
    .wb_retire_cnt(wb_retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_out(input string name, input logic we, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic exc);
    chk({name, ".we"}, {31'd0, wb_we}, {31'd0, we});
    chk({name, ".waddr"}, {27'd0, wb_waddr}, {27'd0, waddr});
    chk({name, ".wdata"}, wb_wdata, wdata);
    chk({name, ".exc"}, {31'd0, wb_exc}, {31'd0, exc});
    chk({name, ".cnt"}, wb_retire_cnt, exp_cnt);
  endtask

  task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic ld, input logic [2:0] op, input logic [1:0] lo,
                       input logic [31:0] rd);
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    mem_is_load = ld; mem_load_op = op; mem_addr_lo = lo; mem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{5'd3,  1'b1, 32'h0, 1'b1, 3'd0, 2'd0, W, 1'b1, 5'd3,  32'hFFFFFF80, 1'b0, 1'b1});
    vecs.push_back('{5'd3,  1'b1, 32'h0, 1'b1, 3'd1, 2'd0, W, 1'b1, 5'd3,  32'h00000080, 1'b0, 1'b1});
    vecs.push_back('{5'd4,  1'b1, 32'h0, 1'b1, 3'd0, 2'd1, W, 1'b1, 5'd4,  32'hFFFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{5'd4,  1'b1, 32'h0, 1'b1, 3'd1, 2'd1, W, 1'b1, 5'd4,  32'h000000FF, 1'b0, 1'b1});
    vecs.push_back('{5'd6,  1'b1, 32'h0, 1'b1, 3'd0, 2'd2, W, 1'b1, 5'd6,  32'h0000007F, 1'b0, 1'b1});
    vecs.push_back('{5'd6,  1'b1, 32'h0, 1'b1, 3'd1, 2'd3, W, 1'b1, 5'd6,  32'h00000001, 1'b0, 1'b1});
    vecs.push_back('{5'd7,  1'b1, 32'h0, 1'b1, 3'd3, 2'd2, W, 1'b1, 5'd7,  32'h00007F01, 1'b0, 1'b1});
    vecs.push_back('{5'd7,  1'b1, 32'h0, 1'b1, 3'd2, 2'd1, W, 1'b0, 5'd7,  32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{5'd8,  1'b1, 32'h0, 1'b1, 3'd2, 2'd0, W, 1'b1, 5'd8,  32'hFFFF80FF, 1'b0, 1'b1});
    vecs.push_back('{5'd8,  1'b1, 32'h0, 1'b1, 3'd3, 2'd0, W, 1'b1, 5'd8,  32'h000080FF, 1'b0, 1'b1});
    vecs.push_back('{5'd9,  1'b1, 32'h0, 1'b1, 3'd2, 2'd2, W, 1'b1, 5'd9,  32'h00007F01, 1'b0, 1'b1});
    vecs.push_back('{5'd9,  1'b1, 32'h0, 1'b1, 3'd3, 2'd3, W, 1'b0, 5'd9,  32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{5'd10, 1'b1, 32'h0, 1'b1, 3'd4, 2'd0, W, 1'b1, 5'd10, 32'h80FF7F01, 1'b0, 1'b1});
    vecs.push_back('{5'd10, 1'b1, 32'h0, 1'b1, 3'd4, 2'd2, W, 1'b0, 5'd10, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{5'd11, 1'b1, 32'h0, 1'b1, 3'd5, 2'd0, W, 1'b0, 5'd11, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{5'd11, 1'b1, 32'h0, 1'b1, 3'd7, 2'd0, W, 1'b0, 5'd11, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{5'd5,  1'b1, 32'h12345678, 1'b0, 3'd0, 2'd0, W, 1'b1, 5'd5, 32'h12345678, 1'b0, 1'b1});
    vecs.push_back('{5'd7,  1'b0, 32'hCAFEF00D, 1'b0, 3'd0, 2'd0, W, 1'b0, 5'd7, 32'hCAFEF00D, 1'b0, 1'b1});
    vecs.push_back('{5'd0,  1'b1, 32'hDEADBEEF, 1'b0, 3'd0, 2'd0, W, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 1'b1});
    vecs.push_back('{5'd0,  1'b1, 32'h0, 1'b1, 3'd4, 2'd1, W, 1'b0, 5'd0,  32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{5'd12, 1'b0, 32'h0, 1'b1, 3'd4, 2'd3, W, 1'b0, 5'd12, 32'h00000000, 1'b0, 1'b0});

    #2;
    chk_out("reset", 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk_out("idle", 1'b0, 5'd0, 32'h0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].ld, vecs[i].op, vecs[i].lo, vecs[i].rdata);
      tick();
      if (vecs[i].e_we) exp_cnt++;
      chk($sformatf("vec%0d.we", i), {31'd0, wb_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("vec%0d.waddr", i), {27'd0, wb_waddr}, {27'd0, vecs[i].e_waddr});
      if (vecs[i].chk_d) chk($sformatf("vec%0d.wdata", i), wb_wdata, vecs[i].e_wdata);
      chk($sformatf("vec%0d.exc", i), {31'd0, wb_exc}, {31'd0, vecs[i].e_exc});
      chk($sformatf("vec%0d.cnt", i), wb_retire_cnt, exp_cnt);
    end

    drive(5'd5, 1'b1, 32'h12345678, 1'b0, 3'd0, 2'd0, 32'h0);
    tick();
    exp_cnt++;
    chk_out("hold.cap", 1'b1, 5'd5, 32'h12345678, 1'b0);
    stall_mem = 1'b1; stall_wb = 1'b1;
    drive(5'd9, 1'b1, 32'hDEADDEAD, 1'b0, 3'd0, 2'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("hold%0d", k), 1'b1, 5'd5, 32'h12345678, 1'b0);
    end

    stall_wb = 1'b0;
    tick();
    chk_out("bubble", 1'b0, 5'd0, 32'h0, 1'b0);

    stall_mem = 1'b0;
    drive(5'd3, 1'b1, 32'h0, 1'b1, 3'd2, 2'd1, W);
    tick();
    chk_out("flush.fault", 1'b0, 5'd3, 32'h0, 1'b1);
    flush = 1'b1; stall_wb = 1'b1;
    drive(5'd4, 1'b1, 32'h55555555, 1'b0, 3'd0, 2'd0, 32'h0);
    tick();
    chk_out("flush.stall", 1'b0, 5'd0, 32'h0, 1'b0);
    flush = 1'b0; stall_wb = 1'b0;

    dut.retire_cnt_q = 32'hFFFFFFFF;
    exp_cnt = 32'hFFFFFFFF;
    drive(5'd2, 1'b1, 32'h00000001, 1'b0, 3'd0, 2'd0, 32'h0);
    tick();
    exp_cnt = 32'h0;
    chk_out("wrap", 1'b1, 5'd2, 32'h00000001, 1'b0);

    drive(5'd6, 1'b1, 32'hAAAA5555, 1'b0, 3'd0, 2'd0, 32'h0);
    tick();
    exp_cnt++;
    stall_wb = 1'b1;
    tick();
    chk_out("rst.held", 1'b1, 5'd6, 32'hAAAA5555, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    exp_cnt = 32'h0;
    chk_out("rst.async", 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk_out("rst.edge", 1'b0, 5'd0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    stall_wb = 1'b0;
    drive(5'd1, 1'b1, 32'h00000011, 1'b0, 3'd0, 2'd0, 32'h0);
    tick();
    exp_cnt++;
    chk_out("rst.after", 1'b1, 5'd1, 32'h00000011, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
